// File: rtl/calc_mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : calc_mult_arbiter
// Purpose  : Round-robin arbiter/sequencer sharing one multiplier core between
//            two requesters; launches, waits for DONE, returns product + ack.
// Revision : 1.0 - initial release
// ============================================================================
module calc_mult_arbiter #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0,
    input  logic [WIDTH-1:0]     a0,
    input  logic [WIDTH-1:0]     b0,
    input  logic                 req1,
    input  logic [WIDTH-1:0]     a1,
    input  logic [WIDTH-1:0]     b1,
    output logic                 ack0,
    output logic                 ack1,
    output logic [2*WIDTH-1:0]   result,
    output logic                 err,
    output logic                 busy,
    output logic                 core_init,
    output logic [WIDTH-1:0]     core_a,
    output logic [WIDTH-1:0]     core_b,
    input  logic                 core_done,
    input  logic [2*WIDTH-1:0]   core_result
);

    // Timeout fires on the last wait cycle so exactly TIMEOUT cycles are spent waiting.
    localparam logic [15:0] c_tmo_last = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_RELEASE   = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic                 r_grant;
    logic                 r_last_grant;
    logic [15:0]          r_cnt;
    logic                 r_ack0;
    logic                 r_ack1;
    logic                 r_err;
    logic [2*WIDTH-1:0]   r_result;
    logic [WIDTH-1:0]     r_core_a;
    logic [WIDTH-1:0]     r_core_b;

    logic                 w_grant_valid;
    logic                 w_pick1;
    logic                 w_done_hit;
    logic                 w_timeout;

    // A stale DONE means the core has not yet returned to its load state.
    assign w_grant_valid = (r_state == ST_IDLE) && !core_done && (req0 || req1);
    assign w_pick1       = req1 && (!req0 || !r_last_grant);
    assign w_done_hit    = (r_state == ST_WAIT_DONE) && core_done;
    assign w_timeout     = (r_state == ST_WAIT_DONE) && !core_done && (r_cnt == c_tmo_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_valid) begin
                    w_state_next = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                w_state_next = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (w_done_hit || w_timeout) begin
                    w_state_next = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!core_done) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_cnt        <= 16'd0;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_err        <= 1'b0;
            r_result     <= '0;
            r_core_a     <= '0;
            r_core_b     <= '0;
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            r_err  <= 1'b0;

            if (w_grant_valid) begin
                r_core_a     <= w_pick1 ? a1 : a0;
                r_core_b     <= w_pick1 ? b1 : b0;
                r_grant      <= w_pick1;
                r_last_grant <= w_pick1;
            end

            if (r_state == ST_LAUNCH) begin
                r_cnt <= 16'd0;
            end else if (r_state == ST_WAIT_DONE) begin
                r_cnt <= r_cnt + 16'd1;
            end

            if (w_done_hit) begin
                r_result <= core_result;
                r_ack0   <= !r_grant;
                r_ack1   <= r_grant;
            end else if (w_timeout) begin
                r_result <= '0;
                r_ack0   <= !r_grant;
                r_ack1   <= r_grant;
                r_err    <= 1'b1;
            end
        end
    end

    assign ack0      = r_ack0;
    assign ack1      = r_ack1;
    assign err       = r_err;
    assign result    = r_result;
    assign core_a    = r_core_a;
    assign core_b    = r_core_b;
    assign busy      = (r_state != ST_IDLE);
    assign core_init = (r_state == ST_LAUNCH);

endmodule
`default_nettype wire

// File: tb/tb_calc_mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_calc_mult_arbiter
// Purpose  : Randomized scoreboard bench for calc_mult_arbiter with a
//            behavioural multiplier core and round-robin reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_calc_mult_arbiter;

    localparam int W  = 16;
    localparam int TO = 30;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            req0 = 1'b0, req1 = 1'b0;
    logic [W-1:0]    a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic            ack0, ack1, err, busy, core_init;
    logic [2*W-1:0]  result;
    logic [W-1:0]    core_a, core_b;
    logic            core_done;
    logic [2*W-1:0]  core_result = '0;
    logic            m_done = 1'b0;
    logic            stale_done = 1'b0;

    assign core_done = m_done | stale_done;

    calc_mult_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .a0(a0), .b0(b0),
        .req1(req1), .a1(a1), .b1(b1),
        .ack0(ack0), .ack1(ack1), .result(result), .err(err), .busy(busy),
        .core_init(core_init), .core_a(core_a), .core_b(core_b),
        .core_done(core_done), .core_result(core_result)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard state
    logic [31:0] cmd0_q[$], cmd1_q[$];
    logic [32:0] exp0_q[$], exp1_q[$];
    int          owner_q[$];
    int          ack_log[$];
    int          m_last = 1;
    int          init_count = 0, err_count = 0;
    int          last_init_cyc = 0, done_rise = -100;
    int          issue_cyc0 = 0, issue_cyc1 = 0;
    logic        act0 = 1'b0, act1 = 1'b0;
    logic        core_never = 1'b0;
    int          done_delay = 20, done_hold = 31;
    int          phase = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Behavioural multiplier core: DONE after a delay, held for a number of cycles.
    initial begin
        logic [W-1:0] la, lb;
        int cnt;
        la = '0; lb = '0; cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                phase = 0;
                m_done = 1'b0;
            end else begin
                case (phase)
                    0: if (core_init) begin
                        la = core_a; lb = core_b;
                        if (!core_never) begin cnt = done_delay; phase = 1; end
                    end
                    1: if (cnt <= 1) begin
                        m_done = 1'b1; core_result = 32'(la) * 32'(lb);
                        cnt = done_hold; phase = 2;
                    end else cnt--;
                    2: if (cnt <= 1) begin
                        m_done = 1'b0; core_result = $urandom; phase = 0;
                    end else cnt--;
                    default: phase = 0;
                endcase
            end
        end
    end

    // Requester agent: hold req and operands until ack, then drop and scramble.
    task automatic run_agent(input int who);
        logic [31:0] op;
        logic [32:0] e;
        logic got;
        int n;
        forever begin
            @(negedge clk);
            if (rst_n && ((who == 0) ? cmd0_q.size() : cmd1_q.size()) != 0) begin
                op = (who == 0) ? cmd0_q.pop_front() : cmd1_q.pop_front();
                e  = core_never ? {1'b1, 32'd0} : {1'b0, 32'(op[31:16]) * 32'(op[15:0])};
                if (who == 0) begin
                    a0 = op[31:16]; b0 = op[15:0]; req0 = 1'b1; act0 = 1'b1;
                    exp0_q.push_back(e); issue_cyc0 = cyc;
                end else begin
                    a1 = op[31:16]; b1 = op[15:0]; req1 = 1'b1; act1 = 1'b1;
                    exp1_q.push_back(e); issue_cyc1 = cyc;
                end
                n = 0; got = 1'b0;
                while (!got && rst_n && n < 600) begin
                    @(negedge clk);
                    n++;
                    got = (who == 0) ? ack0 : ack1;
                end
                if (!got && rst_n) chk("ack_wait_bound", 64'(n), 64'(0));
                if (who == 0) begin
                    req0 = 1'b0; a0 = 16'($urandom); b0 = 16'($urandom); act0 = 1'b0;
                end else begin
                    req1 = 1'b0; a1 = 16'($urandom); b1 = 16'($urandom); act1 = 1'b0;
                end
            end
        end
    endtask

    initial run_agent(0);
    initial run_agent(1);

    // Monitor: reference arbitration at each launch, scoreboard at each ack.
    initial begin
        logic prev_done, prev_rst;
        logic [W-1:0] pa, pb;
        logic [32:0] e;
        int w, who;
        prev_done = 1'b0; prev_rst = 1'b0; pa = '0; pb = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                if (ack0 && ack1) chk("ack_exclusive", {ack0, ack1}, 2'b00);
                if ((core_a !== pa || core_b !== pb) && prev_rst)
                    chk("operands_change_only_on_launch", core_init, 1'b1);
                if (core_init) begin
                    chk("init_core_done_low", core_done, 1'b0);
                    chk("init_busy", busy, 1'b1);
                    chk("init_single_outstanding", 64'(owner_q.size()), 64'(0));
                    if (req0 && req1) w = (m_last == 1) ? 0 : 1;
                    else if (req0) w = 0;
                    else if (req1) w = 1;
                    else w = -1;
                    chk("init_has_request", 64'(w >= 0), 64'(1));
                    if (w == 0) chk("core_ab_req0", {core_a, core_b}, {a0, b0});
                    if (w == 1) chk("core_ab_req1", {core_a, core_b}, {a1, b1});
                    if (w >= 0) begin m_last = w; owner_q.push_back(w); end
                    init_count++;
                    last_init_cyc = cyc;
                end
                if (core_done && !prev_done) done_rise = cyc;
                if (err && !ack0 && !ack1) chk("err_without_ack", err, 1'b0);
                if (ack0 || ack1) begin
                    who = ack1 ? 1 : 0;
                    ack_log.push_back(who);
                    if (owner_q.size() == 0) begin
                        chk("ack_without_launch", 64'(1), 64'(0));
                    end else begin
                        chk("ack_owner", 64'(who), 64'(owner_q.pop_front()));
                        chk("ack_busy", busy, 1'b1);
                        if ((who == 0 ? exp0_q.size() : exp1_q.size()) == 0) begin
                            chk("ack_unexpected", 64'(1), 64'(0));
                        end else begin
                            e = (who == 0) ? exp0_q.pop_front() : exp1_q.pop_front();
                            chk(who == 0 ? "result0" : "result1", result, 64'(e[31:0]));
                            chk(who == 0 ? "err0" : "err1", err, e[32]);
                            if (err) begin
                                err_count++;
                                chk("timeout_latency_window",
                                    64'((cyc - last_init_cyc >= TO + 1) && (cyc - last_init_cyc <= TO + 2)), 64'(1));
                            end else begin
                                chk("ack_one_cycle_after_done", 64'(cyc), 64'(done_rise));
                            end
                        end
                    end
                end
            end
            prev_done = core_done; prev_rst = rst_n; pa = core_a; pb = core_b;
        end
    end

    task automatic drain();
        int n;
        logic ok;
        n = 0; ok = 1'b0;
        while (!ok && n < 3000) begin
            @(negedge clk);
            n++;
            ok = cmd0_q.size() == 0 && cmd1_q.size() == 0 && !act0 && !act1 && !busy
                 && phase == 0 && exp0_q.size() == 0 && exp1_q.size() == 0 && !core_done;
        end
        if (!ok) chk("drain_bound", 64'(n), 64'(0));
    endtask

    task automatic check_log(input string name, input int s0, input int s1, input int s2, input int s3, input int len);
        int seq[4];
        seq = '{s0, s1, s2, s3};
        chk({name, "_len"}, 64'(ack_log.size()), 64'(len));
        for (int i = 0; i < len && i < ack_log.size(); i++)
            chk(name, 64'(ack_log[i]), 64'(seq[i]));
    endtask

    initial begin
        int ic, mode, gap;
        logic [15:0] ra, rb;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctrl", {ack0, ack1, err, busy, core_init}, 5'b0);
        chk("reset_data", {result, core_a, core_b}, 64'd0);
        @(negedge clk); rst_n = 1'b1;

        // Tie right after reset: requester 0 first, no relaunch while DONE is high
        done_delay = 20; done_hold = 31;
        @(posedge clk); ack_log.delete();
        cmd0_q.push_back({16'd7, 16'd9}); cmd1_q.push_back({16'd4, 16'd6});
        drain();
        check_log("tie_order", 0, 1, 0, 0, 2);

        // Fairness with both requesters continuously busy
        done_delay = 5; done_hold = 8;
        @(posedge clk); ack_log.delete();
        for (int i = 0; i < 2; i++) begin
            cmd0_q.push_back({16'($urandom), 16'($urandom)});
            cmd1_q.push_back({16'($urandom), 16'($urandom)});
        end
        drain();
        check_log("fair_order", 0, 1, 0, 1, 4);

        // Single op: launch one cycle after the request is sampled
        done_delay = 20; done_hold = 31;
        @(posedge clk); ic = init_count;
        cmd0_q.push_back({16'd3, 16'd5});
        drain();
        chk("single_init_count", 64'(init_count - ic), 64'(1));
        chk("single_init_latency", 64'(last_init_cyc - issue_cyc0), 64'(1));

        // Randomized traffic including operand extremes and late arrivals
        for (int it = 0; it < 16; it++) begin
            done_delay = $urandom_range(1, 25);
            done_hold  = $urandom_range(1, 35);
            mode = $urandom_range(0, 3);
            @(posedge clk);
            ra = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            if (mode != 1) cmd0_q.push_back({ra, rb});
            if (mode == 3) begin
                gap = $urandom_range(0, 30);
                repeat (gap) @(posedge clk);
            end
            ra = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            rb = 16'($urandom);
            if (mode != 0) cmd1_q.push_back({ra, rb});
            drain();
        end

        // Timeout: core never answers
        core_never = 1'b1;
        @(posedge clk); ic = err_count;
        cmd0_q.push_back({16'($urandom), 16'($urandom)});
        drain();
        core_never = 1'b0;
        chk("timeout_err_seen", 64'(err_count - ic), 64'(1));

        // Stale DONE blocks any launch until it falls
        done_delay = 10; done_hold = 12;
        @(negedge clk); stale_done = 1'b1;
        @(posedge clk); ic = init_count;
        cmd1_q.push_back({16'd11, 16'd13});
        repeat (10) @(negedge clk);
        chk("stale_no_launch", 64'(init_count - ic), 64'(0));
        stale_done = 1'b0;
        drain();
        chk("stale_then_launch", 64'(init_count - ic), 64'(1));

        // Reset during WAIT_DONE
        done_delay = 25; done_hold = 10;
        @(posedge clk); ic = init_count;
        cmd1_q.push_back({16'd21, 16'd2});
        for (int n = 0; n < 100 && init_count == ic; n++) @(negedge clk);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midop_reset_ctrl", {ack0, ack1, err, busy, core_init}, 5'b0);
        chk("midop_reset_data", {result, core_a, core_b}, 64'd0);
        repeat (3) @(negedge clk);
        exp0_q.delete(); exp1_q.delete(); owner_q.delete();
        m_last = 1;
        rst_n = 1'b1;
        done_delay = 6; done_hold = 4;
        @(posedge clk); ack_log.delete();
        cmd0_q.push_back({16'd100, 16'd200}); cmd1_q.push_back({16'd300, 16'd400});
        drain();
        check_log("post_reset_tie", 0, 1, 0, 0, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #600000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
